// File: rtl/im_loader_if.sv
// Byte-stream and instruction-memory write bus for im_loader.
// The master modport is the loader side; the slave modport is the host/memory side.
interface im_loader_if #(
    parameter int AW = 7
) ();
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> big-endian 32-bit IM words.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte over the data bytes.
module im_loader #(
    parameter int NMEM = 128,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    im_loader_if.master   bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t        state_reg;
    logic [15:0]   len_reg;
    logic [23:0]   shift_reg;
    logic [1:0]    byte_cnt_reg;
    logic          byte_ready_reg;
    logic          im_we_reg;
    logic [AW-1:0] im_addr_reg;
    logic [31:0]   im_wdata_reg;
    logic          cpu_hold_reg;
    logic          done_reg;
    logic          err_reg;
    logic [AW:0]   words_loaded_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_reg;
`endif

    logic        accept;
    logic [15:0] len_next;
    logic [16:0] words_inc;

    assign accept    = bus.byte_valid & byte_ready_reg;
    assign len_next  = {len_reg[15:8], bus.byte_in};
    assign words_inc = 17'(words_loaded_reg) + 17'd1;

    assign bus.byte_ready = byte_ready_reg;
    assign bus.im_we      = im_we_reg;
    assign bus.im_addr    = im_addr_reg;
    assign bus.im_wdata   = im_wdata_reg;
    assign cpu_hold       = cpu_hold_reg;
    assign done           = done_reg;
    assign err            = err_reg;
    assign words_loaded   = words_loaded_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            len_reg          <= '0;
            shift_reg        <= '0;
            byte_cnt_reg     <= '0;
            byte_ready_reg   <= 1'b0;
            im_we_reg        <= 1'b0;
            im_addr_reg      <= '0;
            im_wdata_reg     <= '0;
            cpu_hold_reg     <= 1'b1;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            words_loaded_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg          <= '0;
`endif
        end else begin
            im_we_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_reg        <= S_LEN_HI;
                        byte_ready_reg   <= 1'b1;
                        cpu_hold_reg     <= 1'b1;
                        done_reg         <= 1'b0;
                        err_reg          <= 1'b0;
                        words_loaded_reg <= '0;
                        im_addr_reg      <= '0;
                        byte_cnt_reg     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_reg          <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_reg[15:8] <= bus.byte_in;
                        state_reg     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_reg <= len_next;
                        if (len_next == 16'd0 || len_next > 16'(NMEM)) begin
                            state_reg      <= S_ERR;
                            byte_ready_reg <= 1'b0;
                            err_reg        <= 1'b1;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shift_reg    <= {shift_reg[15:0], bus.byte_in};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_reg      <= sum_reg + bus.byte_in;
`endif
                        // Fourth byte completes the word; the write strobe is
                        // registered here so it is high for exactly the WRITE cycle.
                        if (byte_cnt_reg == 2'd3) begin
                            state_reg      <= S_WRITE;
                            byte_ready_reg <= 1'b0;
                            im_we_reg      <= 1'b1;
                            im_addr_reg    <= words_loaded_reg[AW-1:0];
                            im_wdata_reg   <= {shift_reg, bus.byte_in};
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded_reg <= words_inc[AW:0];
                    if (words_inc < {1'b0, len_reg}) begin
                        state_reg      <= S_DATA;
                        byte_ready_reg <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state_reg      <= S_CHK;
                        byte_ready_reg <= 1'b1;
`else
                        state_reg      <= S_DONE;
                        done_reg       <= 1'b1;
                        cpu_hold_reg   <= 1'b0;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        byte_ready_reg <= 1'b0;
                        if (bus.byte_in == sum_reg) begin
                            state_reg    <= S_DONE;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= S_ERR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_reg      <= S_IDLE;
                    byte_ready_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader; follows LOADER_CHECKSUM_EN like the RTL.
`timescale 1ns/1ps
module tb_im_loader;
    localparam int AW = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cpu_hold, done, err;
    logic [AW:0] words_loaded;

    im_loader_if #(.AW(AW)) ifc ();

    im_loader #(.NMEM(128), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(ifc.master),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          wr_base;
    bit          gap_en = 1'b0;
    logic [7:0]  csum;
    logic [31:0] mem_obs [0:127];
    logic [AW-1:0] log_addr [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Write monitor: records every IM write and checks the stream is stalled during it.
    always @(negedge clk) begin
        if (ifc.im_we === 1'b1) begin
            chk("we_ready_low", 32'(ifc.byte_ready), 32'd0);
            mem_obs[ifc.im_addr] = ifc.im_wdata;
            if (wr_cnt < 64) log_addr[wr_cnt] = ifc.im_addr;
            wr_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        ifc.byte_in    = b;
        ifc.byte_valid = 1'b1;
        t = 0;
        while (ifc.byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%h ready stuck low", b);
        end
        @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] b);
        if (gap_en) begin
            ifc.byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        send_byte(b);
        csum = csum + b;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_data(w[31:24]);
        send_data(w[23:16]);
        send_data(w[15:8]);
        send_data(w[7:0]);
    endtask

    task automatic send_chk();
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum);
`endif
        ifc.byte_valid = 1'b0;
    endtask

    task automatic start_load();
        ifc.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        csum = 8'd0;
    endtask

    task automatic wait_end();
        int t;
        ifc.byte_valid = 1'b0;
        t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL wait_end timeout done=%b err=%b", done, err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.byte_in    = 8'h00;
        ifc.byte_valid = 1'b0;
        csum           = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",    32'(ifc.byte_ready), 32'd0);
        chk("rst_we",       32'(ifc.im_we),      32'd0);
        chk("rst_addr",     32'(ifc.im_addr),    32'd0);
        chk("rst_wdata",    ifc.im_wdata,        32'd0);
        chk("rst_hold",     32'(cpu_hold),       32'd1);
        chk("rst_done",     32'(done),           32'd0);
        chk("rst_err",      32'(err),            32'd0);
        chk("rst_words",    32'(words_loaded),   32'd0);

        // Test 1: two words, valid held high
        wr_cnt = 0;
        start_load();
        chk("t1_start_ready", 32'(ifc.byte_ready), 32'd1);
        chk("t1_start_hold",  32'(cpu_hold),       32'd1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h20080005);
        send_word(32'h01095020);
        chk("t1_we_k1",    32'(ifc.im_we),      32'd1);
        chk("t1_addr_k1",  32'(ifc.im_addr),    32'd1);
        chk("t1_wdata_k1", ifc.im_wdata,        32'h01095020);
        chk("t1_ready_k1", 32'(ifc.byte_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        send_chk();
        wait_end();
`else
        @(negedge clk);
`endif
        chk("t1_done",  32'(done),         32'd1);
        chk("t1_hold",  32'(cpu_hold),     32'd0);
        chk("t1_words", 32'(words_loaded), 32'd2);
        @(negedge clk);
        chk("t1_wr_cnt", 32'(wr_cnt),      32'd2);
        chk("t1_addr0",  32'(log_addr[0]), 32'd0);
        chk("t1_addr1",  32'(log_addr[1]), 32'd1);
        chk("t1_mem0",   mem_obs[0],       32'h20080005);
        chk("t1_mem1",   mem_obs[1],       32'h01095020);
        chk("t1_addr_hold", 32'(ifc.im_addr), 32'd1);

        // Test 2: length rejection and restart from ERR
        wr_base = wr_cnt;
        start_load();
        chk("t2_start_done", 32'(done), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t2_len0_err",   32'(err),            32'd1);
        chk("t2_len0_hold",  32'(cpu_hold),       32'd1);
        chk("t2_len0_ready", 32'(ifc.byte_ready), 32'd0);
        start_load();
        chk("t2_restart_err",   32'(err),            32'd0);
        chk("t2_restart_ready", 32'(ifc.byte_ready), 32'd1);
        send_byte(8'h00);
        send_byte(8'h81);
        chk("t2_len129_err", 32'(err), 32'd1);
        start_load();
        send_byte(8'h01);
        send_byte(8'h00);
        chk("t2_len256_err", 32'(err), 32'd1);
        start_load();
        send_byte(8'h00);
        send_byte(8'h80);
        chk("t2_len128_err",   32'(err),            32'd0);
        chk("t2_len128_ready", 32'(ifc.byte_ready), 32'd1);
        ifc.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t2_no_writes", 32'(wr_cnt - wr_base), 32'd0);
        start_load();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hAABBCCDD);
        send_chk();
        wait_end();
        chk("t2_one_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("t2_one_mem0", mem_obs[0], 32'hAABBCCDD);

        // Test 3: three words with random valid gaps
        gap_en  = 1'b1;
        wr_base = wr_cnt;
        start_load();
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_word(32'h99AABBCC);
        send_chk();
        wait_end();
        chk("t3_done",  32'(done),         32'd1);
        chk("t3_words", 32'(words_loaded), 32'd3);
        @(negedge clk);
        chk("t3_wr_cnt", 32'(wr_cnt - wr_base), 32'd3);
        chk("t3_mem0",   mem_obs[0], 32'h11223344);
        chk("t3_mem1",   mem_obs[1], 32'h55667788);
        chk("t3_mem2",   mem_obs[2], 32'h99AABBCC);
        gap_en = 1'b0;

        // Test 4: reset after 6 data bytes of a 2-word load
        wr_base = wr_cnt;
        start_load();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'hDEADBEEF);
        send_data(8'h12);
        send_data(8'h34);
        ifc.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_ready", 32'(ifc.byte_ready), 32'd0);
        chk("t4_we",    32'(ifc.im_we),      32'd0);
        chk("t4_hold",  32'(cpu_hold),       32'd1);
        chk("t4_done",  32'(done),           32'd0);
        chk("t4_words", 32'(words_loaded),   32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        chk("t4_mem0",   mem_obs[0], 32'hDEADBEEF);
        chk("t4_mem1",   mem_obs[1], 32'h55667788);

        // Test 6: start ignored in DATA, start in DONE reloads
        start_load();
        send_byte(8'h00);
        send_byte(8'h01);
        send_data(8'h01);
        send_data(8'h02);
        ifc.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_data(8'h03);
        send_data(8'h04);
        send_chk();
        wait_end();
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_err",  32'(err),  32'd0);
        @(negedge clk);
        chk("t6_mem0", mem_obs[0], 32'h01020304);
        start_load();
        chk("t6_reload_done",  32'(done),         32'd0);
        chk("t6_reload_hold",  32'(cpu_hold),     32'd1);
        chk("t6_reload_words", 32'(words_loaded), 32'd0);
        chk("t6_reload_addr",  32'(ifc.im_addr),  32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_data(8'hCA);
        send_data(8'hFE);
        chk("t6_mid_hold", 32'(cpu_hold), 32'd1);
        send_data(8'hBA);
        send_data(8'hBE);
        send_chk();
        wait_end();
        chk("t6_again_done",  32'(done),         32'd1);
        chk("t6_again_hold",  32'(cpu_hold),     32'd0);
        chk("t6_again_words", 32'(words_loaded), 32'd1);
        @(negedge clk);
        chk("t6_again_mem0", mem_obs[0], 32'hCAFEBABE);

`ifdef LOADER_CHECKSUM_EN
        // Test 5: checksum accept and reject
        start_load();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h01020304);
        send_byte(8'h0A);
        wait_end();
        chk("t5_good_done", 32'(done), 32'd1);
        start_load();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h01020304);
        mem_obs[0] = 32'h0;
        send_byte(8'h0B);
        wait_end();
        chk("t5_bad_err",  32'(err),      32'd1);
        chk("t5_bad_hold", 32'(cpu_hold), 32'd1);
        chk("t5_bad_mem0", mem_obs[0],    32'h01020304);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
